// File: rtl/pattern_scheduler.sv
// pattern_scheduler: picks the bitwise test pattern and key mask for the video
// generator. Inputs are synchronised and debounced; manual and automatic change
// requests are merged; changes are committed only on a vblank rising edge.
module pattern_scheduler #(
  parameter int NUM_PATTERNS    = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int AUTO_TICKS      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] key,
  input  logic       next_btn,
  input  logic       auto_en,
  input  logic       auto_tick,
  input  logic       vblank,
  output logic [2:0] pattern_sel,
  output logic [8:0] key_mask,
  output logic       pending,
  output logic       update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(AUTO_TICKS - 1);
  localparam logic [2:0]    PAT_MAX  = 3'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_t;

  state_t        state;
  logic [8:0]    key_s1, key_s2, key_cand, key_stable, key_stable_q;
  logic          btn_s1, btn_s2, btn_cand, btn_stable, btn_stable_q;
  logic [CW-1:0] key_cnt, btn_cnt;
  logic [TW-1:0] tick_cnt;
  logic          vblank_q;
  logic          adv_pend, key_pend;

  logic key_req, adv_req, auto_req, adv_any, any_req, frame_edge;

  assign key_req    = key_stable != key_stable_q;
  assign adv_req    = btn_stable & ~btn_stable_q;
  assign auto_req   = auto_en & auto_tick & (tick_cnt == TICK_MAX);
  assign adv_any    = adv_req | auto_req;
  assign any_req    = adv_any | key_req;
  assign frame_edge = vblank & ~vblank_q;

  // Two-flop synchronisers for the asynchronous switch and button inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1 <= '0; key_s2 <= '0;
      btn_s1 <= 1'b0; btn_s2 <= 1'b0;
    end else begin
      key_s1 <= key;    key_s2 <= key_s1;
      btn_s1 <= next_btn; btn_s2 <= btn_s1;
    end
  end

  // Key debouncer: the candidate must hold for DEBOUNCE_CYCLES before it is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_cand <= '0; key_cnt <= '0; key_stable <= '0;
    end else begin
      if (key_s2 != key_cand) begin
        key_cand <= key_s2;
        key_cnt  <= '0;
      end else if (key_cnt != CNT_MAX) begin
        key_cnt <= key_cnt + 1'b1;
      end
      if (key_cnt == CNT_MAX && key_cand != key_stable) key_stable <= key_cand;
    end
  end

  // Button debouncer, same scheme as the key path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_cand <= 1'b0; btn_cnt <= '0; btn_stable <= 1'b0;
    end else begin
      if (btn_s2 != btn_cand) begin
        btn_cand <= btn_s2;
        btn_cnt  <= '0;
      end else if (btn_cnt != CNT_MAX) begin
        btn_cnt <= btn_cnt + 1'b1;
      end
      if (btn_cnt == CNT_MAX && btn_cand != btn_stable) btn_stable <= btn_cand;
    end
  end

  // Delayed copies used for change / rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_stable_q <= '0; btn_stable_q <= 1'b0; vblank_q <= 1'b0;
    end else begin
      key_stable_q <= key_stable;
      btn_stable_q <= btn_stable;
      vblank_q     <= vblank;
    end
  end

  // Tempo divider: counts ticks only while auto mode is enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tick_cnt <= '0;
    else if (!auto_en)      tick_cnt <= '0;
    else if (auto_tick)     tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
  end

  // Request arbitration and frame-synchronous commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      adv_pend    <= 1'b0;
      key_pend    <= 1'b0;
      pattern_sel <= '0;
      key_mask    <= '0;
      pending     <= 1'b0;
      update      <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        IDLE: begin
          // a request in a frame_edge cycle still waits for the next frame
          if (any_req) begin
            state    <= WAIT;
            pending  <= 1'b1;
            adv_pend <= adv_any;
            key_pend <= key_req;
          end
        end
        WAIT: begin
          adv_pend <= adv_pend | adv_any;
          key_pend <= key_pend | key_req;
          if (frame_edge) state <= APPLY;
        end
        APPLY: begin
          if (adv_pend) pattern_sel <= (pattern_sel == PAT_MAX) ? 3'd0 : pattern_sel + 3'd1;
          if (key_pend) key_mask <= key_stable;
          update   <= 1'b1;
          // requests arriving during the commit are kept for the next frame
          adv_pend <= adv_any;
          key_pend <= key_req;
          pending  <= any_req;
          state    <= any_req ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler: directed scenarios plus random stimulus, all
// outputs compared every cycle against a sample-window / request-set model.
module tb_pattern_scheduler;
  localparam int D  = 4;
  localparam int AT = 2;
  localparam int NP = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] key = '0;
  logic       next_btn = 1'b0, auto_en = 1'b0, auto_tick = 1'b0, vblank = 1'b0;
  logic [2:0] pattern_sel;
  logic [8:0] key_mask;
  logic       pending, update;

  int n_tests = 0, n_fail = 0, upd_seen = 0;

  always #5 clk = ~clk;

  pattern_scheduler #(.NUM_PATTERNS(NP), .DEBOUNCE_CYCLES(D), .AUTO_TICKS(AT)) dut (
    .clk(clk), .reset(reset), .key(key), .next_btn(next_btn), .auto_en(auto_en),
    .auto_tick(auto_tick), .vblank(vblank), .pattern_sel(pattern_sel),
    .key_mask(key_mask), .pending(pending), .update(update)
  );

  // ---------------- behavioural model ----------------
  // Raw samples taken at each edge; index 0 = newest. A value is accepted once
  // D consecutive samples agree, seen through the 3-edge sync/candidate delay.
  logic [8:0] kq[$];
  bit         bq[$];
  logic [8:0] m_ks, m_mask;
  bit         m_kchg, m_bs, m_brise, m_vprev;
  bit         want_adv, want_key, m_apply, m_upd, m_pend;
  int         m_ticks, m_pat;

  task automatic m_reset();
    kq = {}; bq = {};
    for (int i = 0; i < D + 3; i++) begin kq.push_back(9'h0); bq.push_back(1'b0); end
    m_ks = '0; m_mask = '0; m_kchg = 0; m_bs = 0; m_brise = 0; m_vprev = 0;
    want_adv = 0; want_key = 0; m_apply = 0; m_upd = 0; m_pend = 0;
    m_ticks = 0; m_pat = 0;
  endtask

  task automatic m_step();
    bit adv_r, key_r, auto_r, frame, had, same;
    key_r  = m_kchg;
    adv_r  = m_brise;
    auto_r = auto_en && auto_tick && (m_ticks + 1 == AT);
    frame  = vblank && !m_vprev;
    if (m_apply) begin
      if (want_adv) m_pat = (m_pat + 1) % NP;
      if (want_key) m_mask = m_ks;
      m_upd    = 1;
      want_adv = adv_r || auto_r;
      want_key = key_r;
      m_apply  = 0;
    end else begin
      m_upd    = 0;
      had      = want_adv || want_key;
      want_adv = want_adv || adv_r || auto_r;
      want_key = want_key || key_r;
      m_apply  = had && frame;
    end
    m_pend  = want_adv || want_key;
    m_vprev = vblank;
    if (!auto_en) m_ticks = 0;
    else if (auto_tick) begin
      m_ticks++;
      if (m_ticks == AT) m_ticks = 0;
    end
    kq.push_front(key);      void'(kq.pop_back());
    bq.push_front(next_btn); void'(bq.pop_back());
    same = 1;
    for (int j = 4; j <= D + 2; j++) if (kq[j] != kq[3]) same = 0;
    m_kchg = same && (kq[3] != m_ks);
    if (m_kchg) m_ks = kq[3];
    same = 1;
    for (int j = 4; j <= D + 2; j++) if (bq[j] != bq[3]) same = 0;
    m_brise = same && bq[3] && !m_bs;
    if (same) m_bs = bq[3];
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else       m_step();
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("pattern_sel", {29'b0, pattern_sel}, m_pat);
    check("key_mask", {23'b0, key_mask}, {23'b0, m_mask});
    check("pending", {31'b0, pending}, {31'b0, m_pend});
    check("update", {31'b0, update}, {31'b0, m_upd});
    if (update === 1'b1) upd_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vblank = 1'b1; cyc(4); vblank = 1'b0; cyc(4);
  endtask

  task automatic press();
    next_btn = 1'b1; cyc(10); next_btn = 1'b0; cyc(10);
  endtask

  task automatic tick();
    auto_tick = 1'b1; cyc(1); auto_tick = 1'b0; cyc(1);
  endtask

  int exp_seq[5] = '{1, 2, 3, 4, 0};
  int u0;
  logic [8:0] kvals[4] = '{9'h0A5, 9'h1FF, 9'h003, 9'h100};

  initial begin
    #1 reset = 1'b1;
    cyc(3); reset = 1'b0; cyc(1);
    check("reset_pat", {29'b0, pattern_sel}, 0);
    check("reset_mask", {23'b0, key_mask}, 0);
    check("reset_pending", {31'b0, pending}, 0);

    // key debounce and commit
    key = 9'h0A5; cyc(10);
    check("key_pending", {31'b0, pending}, 1);
    u0 = upd_seen; frame();
    check("key_mask_commit", {23'b0, key_mask}, 32'h0A5);
    check("key_pat_unchanged", {29'b0, pattern_sel}, 0);
    check("key_one_update", upd_seen - u0, 1);
    key = 9'h1FF; cyc(3); key = 9'h0A5; cyc(10);
    check("glitch_no_pending", {31'b0, pending}, 0);
    frame();
    check("glitch_mask", {23'b0, key_mask}, 32'h0A5);

    // manual advance with wrap
    for (int i = 0; i < 5; i++) begin
      press(); frame();
      check("adv_wrap", {29'b0, pattern_sel}, exp_seq[i]);
    end

    // three presses inside one frame coalesce
    press(); press(); press(); frame();
    check("coalesce", {29'b0, pattern_sel}, 1);

    // adv_req coincident with frame_edge while idle
    next_btn = 1'b1; cyc(7); vblank = 1'b1; cyc(4);
    check("edge_req_pending", {31'b0, pending}, 1);
    check("edge_req_no_commit", {29'b0, pattern_sel}, 1);
    vblank = 1'b0; next_btn = 1'b0; cyc(10); frame();
    check("edge_req_commit", {29'b0, pattern_sel}, 2);

    // asynchronous reset while a change is waiting
    key = 9'h000;
    next_btn = 1'b1; cyc(10); next_btn = 1'b0;
    check("pre_reset_pending", {31'b0, pending}, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pat", {29'b0, pattern_sel}, 0);
    check("async_rst_mask", {23'b0, key_mask}, 0);
    check("async_rst_pending", {31'b0, pending}, 0);
    cyc(2); reset = 1'b0; cyc(12);
    u0 = upd_seen; frame();
    check("post_reset_no_update", upd_seen - u0, 0);
    check("post_reset_pending", {31'b0, pending}, 0);

    // automatic advance: tick every 100 cycles, frame every 60
    auto_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      auto_tick = (c % 100 == 99);
      vblank    = (c % 60) >= 40;
      cyc(1);
    end
    auto_tick = 1'b0; vblank = 1'b0; cyc(4); frame();
    auto_en = 1'b0; cyc(2); auto_en = 1'b1;
    tick();
    auto_en = 1'b0; cyc(3); tick(); tick();
    auto_en = 1'b1; cyc(1); tick(); cyc(3);
    check("auto_restart", {31'b0, pending}, 0);
    tick(); cyc(2);
    check("auto_second_tick", {31'b0, pending}, 1);
    frame(); auto_en = 1'b0; cyc(2);

    // random stimulus
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) key = kvals[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) next_btn = ~next_btn;
      if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
      auto_tick = ($urandom_range(0, 19) == 0);
      vblank = ((c % 40) >= 30) ^ ($urandom_range(0, 29) == 0);
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Frame-synchronous controller that decides which bitwise test pattern (OR, XOR, AND, AND-NOT, XNOR of the pixel counters) and which 9-bit key mask the HDMI video generator uses. Inputs are the raw key switches, a "next pattern" button and the half-second tempo pulse. The block debounces the inputs and arbitrates between manual and automatic change requests. It commits every change only at the start of vertical blanking, so a pattern never switches mid-frame. It runs in the pixel clock domain, beside the sync counters.

## Interface

Parameters:
- NUM_PATTERNS, 5, number of selectable patterns; pattern_sel wraps from NUM_PATTERNS-1 to 0
- DEBOUNCE_CYCLES, 250000, number of consecutive stable clk cycles required before a key or button change is accepted (minimum 2)
- AUTO_TICKS, 4, number of auto_tick pulses between automatic pattern advances (minimum 1)

Ports:
- clk  input  1  pixel clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- key  input  9  raw key switches; asynchronous to clk
- next_btn  input  1  raw "next pattern" button, active-high; asynchronous to clk
- auto_en  input  1  level; enables automatic advance; synchronous to clk
- auto_tick  input  1  one-cycle tempo pulse; synchronous to clk
- vblank  input  1  level, high outside the active vertical range; synchronous to clk
- pattern_sel  output  3  committed pattern index, 0..NUM_PATTERNS-1
- key_mask  output  9  committed key mask compared against the pattern bits
- pending  output  1  high while a change is waiting for the next frame edge
- update  output  1  one-cycle pulse in the cycle after outputs change

## Operation

- **Synchronisers.** key and next_btn each pass through a 2-flop synchroniser.
- **Debounce.** One independent debouncer for key (as a 9-bit vector) and one for next_btn.
  - Each debouncer has a counter that clears whenever the synchronised value differs from the candidate value; the candidate then loads the new value.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the candidate differs from the stable value, the stable value loads the candidate.
  - The counter saturates; it never wraps.
- **Manual requests.**
  - key_req pulses for one cycle when key_stable changes.
  - adv_req pulses for one cycle on a rising edge of btn_stable.
- **Automatic requests.**
  - tick_cnt counts auto_tick pulses only while auto_en=1, and clears whenever auto_en=0.
  - When a pulse brings tick_cnt to AUTO_TICKS, tick_cnt clears and auto_req pulses.
- **Arbitration.**
  - Pending flags are adv_pend and key_pend.
  - adv_req or auto_req sets adv_pend. key_req sets key_pend.
  - If adv_req and auto_req occur in the same cycle, they merge into one advance; manual takes priority and the auto request is dropped.
  - Further requests while a flag is already set do not accumulate: at most one advance per frame.
  - The latest key_stable is always the value committed.
- **Frame edge.** frame_edge = vblank & ~vblank_q, where vblank_q is vblank registered.
- **State machine.**
  - IDLE: no flag set. Go to WAIT when any request occurs, even in a frame_edge cycle; that request waits for the next frame.
  - WAIT: pending=1. Go to APPLY on frame_edge.
  - APPLY: lasts one cycle.
    - If adv_pend is set, pattern_sel advances by one, wrapping at NUM_PATTERNS-1.
    - If key_pend is set, key_mask loads key_stable.
    - Both flags clear.
    - Next state is IDLE. If a request arrives in the APPLY cycle, it is captured and the next state is WAIT instead.
- **Arithmetic.** The pattern increment compares against NUM_PATTERNS-1. There is no modulo; values ≥ NUM_PATTERNS never appear.

## Timing

- **Reset values.** pattern_sel=0, key_mask=0, pending=0, update=0. All counters, flags, synchronisers, stable values and vblank_q are 0. State is IDLE.
- **Reset mid-operation.** Reset asserted at any time, including during WAIT or APPLY, discards pending requests immediately. It does not wait for a clock.
- **Key latency.** 2 cycles of synchronisation plus DEBOUNCE_CYCLES cycles to key_req. pending rises in the cycle after key_req.
- **Frame commit.**
  - If vblank rises at edge E (vblank_q=0 at E), state is APPLY after E+1.
  - pattern_sel and key_mask change at E+2.
  - update is high for the cycle after E+2, then returns low.
  - pending falls at E+2.
- **Glitch rejection.** A glitch shorter than DEBOUNCE_CYCLES never reaches the outputs.
- **Continuous vblank.** vblank held high produces exactly one frame_edge.
- **Minimum spacing.** Outputs change at most once per vblank rising edge.

## Test plan

- **Reset.** Assert reset mid-WAIT with adv_pend=1 → outputs 0 and pending=0 asynchronously. After release, a vblank rise gives no update.
- **Key debounce.** DEBOUNCE_CYCLES=4. key=9'h0A5 held 10 cycles → pending=1. Next vblank rise → key_mask=9'h0A5, pattern_sel unchanged, one update pulse. A 3-cycle pulse to 9'h1FF → no pending.
- **Manual advance and wrap.** Five debounced next_btn presses, each followed by a frame → pattern_sel goes 1,2,3,4,0.
- **Coalescing.** Three presses within one frame → pattern_sel advances by exactly 1 at the next frame edge.
- **Auto mode.** AUTO_TICKS=2, auto_en=1, tick every 100 cycles, frames every 60 cycles → pattern_sel advances once per 2 ticks. auto_en=0 → no further advances, and tick_cnt restarts from 0 on re-enable.
- **Request on the frame edge.** adv_req in the same cycle as frame_edge while IDLE → no commit on that edge; commit on the following vblank rise.
